threshold_edge_detector: RTL and testbench



---
 rtl/threshold_edge_detector.sv | 141 ++++++++++++++
 tb/tb_threshold_edge_detector.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/threshold_edge_detector.sv
// Hysteresis + hold-count edge detector on the ADC stream against the sequencer threshold.
// Edge pulses are registered one cycle after the completing sample; no backpressure (stream input).
module threshold_edge_detector #(
  parameter int                DATA_W       = 16,
  parameter logic [DATA_W-1:0] HYST         = 16'd64,
  parameter int                HOLD_SAMPLES = 4
) (
  input  logic              adc_clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] thresholdoutput,
  input  logic              enable,
  output logic              edgerise_logical,
  output logic              edgefall_logical,
  output logic              level_high,
  output logic [15:0]       edge_count
);

  typedef enum logic [2:0] {
    S_INIT,
    S_LOW,
    S_QUAL_RISE,
    S_HIGH,
    S_QUAL_FALL
  } state_t;

  localparam logic [DATA_W-1:0] MAX_VAL = {DATA_W{1'b1}};
  localparam logic [7:0]        HOLD8   = 8'(HOLD_SAMPLES);

  state_t            state;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] thr_q;
  logic [DATA_W-1:0] upper_q;
  logic [DATA_W-1:0] lower_q;
  logic              band_stale;

  logic [DATA_W:0]   up_sum;
  logic [DATA_W-1:0] upper_nxt;
  logic [DATA_W-1:0] lower_nxt;
  logic              above;
  logic              below;
  logic [7:0]        cnt_inc;
  logic              thr_change;
  logic              run;
  logic              rise_done;
  logic              fall_done;

  always_comb begin
    up_sum     = {1'b0, thr_q} + {1'b0, HYST};
    upper_nxt  = up_sum[DATA_W] ? MAX_VAL : up_sum[DATA_W-1:0];
    lower_nxt  = (thr_q > HYST) ? (thr_q - HYST) : '0;
    above      = adc_data > upper_q;
    below      = adc_data < lower_q;
    cnt_inc    = cnt + 8'd1;
    thr_change = thresholdoutput != thr_q;
    // band registers lag the threshold latch by one cycle; ignore samples until they settle
    run        = !thr_change && enable && adc_valid && !band_stale;
    rise_done  = run && above &&
                 ((state == S_LOW && HOLD8 == 8'd1) || (state == S_QUAL_RISE && cnt_inc == HOLD8));
    fall_done  = run && below &&
                 ((state == S_HIGH && HOLD8 == 8'd1) || (state == S_QUAL_FALL && cnt_inc == HOLD8));
  end

  always_ff @(posedge adc_clk) begin
    if (!reset_n) begin
      state            <= S_INIT;
      cnt              <= '0;
      thr_q            <= '0;
      upper_q          <= '0;
      lower_q          <= '0;
      band_stale       <= 1'b1;
      edgerise_logical <= 1'b0;
      edgefall_logical <= 1'b0;
      level_high       <= 1'b0;
      edge_count       <= '0;
    end else begin
      upper_q          <= upper_nxt;
      lower_q          <= lower_nxt;
      band_stale       <= 1'b0;
      edgerise_logical <= 1'b0;
      edgefall_logical <= 1'b0;
      if (thr_change) begin
        thr_q      <= thresholdoutput;
        band_stale <= 1'b1;
        state      <= S_INIT;
        cnt        <= '0;
      end else if (!enable) begin
        state <= S_INIT;
        cnt   <= '0;
      end else if (rise_done || fall_done) begin
        state            <= rise_done ? S_HIGH : S_LOW;
        level_high       <= rise_done;
        edgerise_logical <= rise_done;
        edgefall_logical <= fall_done;
        cnt              <= '0;
        if (edge_count != 16'hFFFF) edge_count <= edge_count + 16'd1;
      end else if (run) begin
        case (state)
          S_INIT: begin
            if (above) begin
              state      <= S_HIGH;
              level_high <= 1'b1;
            end else if (below) begin
              state      <= S_LOW;
              level_high <= 1'b0;
            end
          end
          S_LOW: begin
            if (above) begin
              cnt   <= 8'd1;
              state <= S_QUAL_RISE;
            end
          end
          S_QUAL_RISE: begin
            if (above) cnt <= cnt_inc;
            else begin
              cnt   <= '0;
              state <= S_LOW;
            end
          end
          S_HIGH: begin
            if (below) begin
              cnt   <= 8'd1;
              state <= S_QUAL_FALL;
            end
          end
          S_QUAL_FALL: begin
            if (below) cnt <= cnt_inc;
            else begin
              cnt   <= '0;
              state <= S_HIGH;
            end
          end
          default: state <= S_INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_threshold_edge_detector.sv
// Directed bench for threshold_edge_detector: main instance with HOLD_SAMPLES=4,
// second instance with HOLD_SAMPLES=1 to reach edge_count saturation quickly.
module tb_threshold_edge_detector;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] adc_data, thr;
  logic        adc_valid, enable;
  logic        rise, fall, level;
  logic [15:0] count;

  logic [15:0] adc_data2, thr2;
  logic        adc_valid2, enable2;
  logic        rise2, fall2, level2;
  logic [15:0] count2;

  int tests  = 0;
  int failed = 0;
  logic seen;

  always #5 clk = ~clk;

  threshold_edge_detector dut (
    .adc_clk(clk), .reset_n(reset_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .thresholdoutput(thr), .enable(enable), .edgerise_logical(rise),
    .edgefall_logical(fall), .level_high(level), .edge_count(count)
  );

  threshold_edge_detector #(.HOLD_SAMPLES(1)) dut2 (
    .adc_clk(clk), .reset_n(reset_n), .adc_data(adc_data2), .adc_valid(adc_valid2),
    .thresholdoutput(thr2), .enable(enable2), .edgerise_logical(rise2),
    .edgefall_logical(fall2), .level_high(level2), .edge_count(count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [15:0] d);
    adc_data  = d;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    adc_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_all(input string tag, input logic r, input logic f,
                           input logic l, input logic [15:0] c);
    check({tag, "_rise"},  rise,  r);
    check({tag, "_fall"},  fall,  f);
    check({tag, "_level"}, level, l);
    check({tag, "_count"}, count, c);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; thr = 16'h0000; adc_data = '0; adc_valid = 1'b0;
    thr2 = 16'h8000; enable2 = 1'b1; adc_data2 = '0; adc_valid2 = 1'b0;

    // reset and acquire
    tick(); tick();
    check_all("reset", 0, 0, 0, 16'd0);
    reset_n = 1'b1; thr = 16'h8000; enable = 1'b1;
    idle(3);
    sample(16'h7000);
    check_all("acquire_low", 0, 0, 0, 16'd0);

    // clean rise
    sample(16'h8100); sample(16'h8100); sample(16'h8100);
    check("rise_3rd_none", rise, 1'b0);
    sample(16'h8100);
    check_all("rise_pulse", 1, 0, 1, 16'd1);
    idle(1);
    check("rise_one_cycle", rise, 1'b0);

    // back to LOW
    for (int i = 0; i < 4; i++) sample(16'h7000);
    check_all("fall_pulse", 0, 1, 0, 16'd2);
    idle(1);
    check("fall_one_cycle", fall, 1'b0);

    // glitch rejection
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin sample(16'h8100); seen |= rise | fall; end
    sample(16'h8000); seen |= rise | fall;
    for (int i = 0; i < 3; i++) begin sample(16'h8100); seen |= rise | fall; end
    check("glitch_no_pulse", seen, 1'b0);
    sample(16'h8100);
    check_all("glitch_then_rise", 1, 0, 1, 16'd3);

    // hysteresis band and valid gaps
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin sample(16'h7FD0); seen |= rise | fall; end
    check("inband_no_fall", seen, 1'b0);
    for (int i = 0; i < 3; i++) begin sample(16'h7F00); seen |= fall; idle(1); seen |= fall; end
    check("gap_no_early_fall", seen, 1'b0);
    sample(16'h7F00);
    check_all("gap_fall", 0, 1, 0, 16'd4);
    idle(1);
    check_all("gap_fall_done", 0, 0, 0, 16'd4);

    // threshold change mid-qualification
    sample(16'h8100); sample(16'h8100);
    thr = 16'h9000;
    idle(1);
    check("thr_change_no_pulse", rise | fall, 1'b0);
    idle(2);
    sample(16'h8100);
    check_all("new_band_low", 0, 0, 0, 16'd4);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin sample(16'h9100); seen |= rise; end
    check("new_band_qual", seen, 1'b0);
    sample(16'h9100);
    check_all("new_band_rise", 1, 0, 1, 16'd5);

    // upper saturates at 0xFFFF
    thr = 16'hFFF0; idle(3);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin sample(16'hFFFF); seen |= rise | fall; end
    check_all("sat_hi_init", 0, 0, 1, 16'd5);
    check("sat_hi_none", seen, 1'b0);
    sample(16'h0000);
    check_all("sat_hi_low", 0, 0, 0, 16'd5);
    for (int i = 0; i < 6; i++) begin sample(16'hFFFF); seen |= rise | fall; end
    check("sat_hi_never_above", seen, 1'b0);

    // lower clamps at 0
    thr = 16'h0010; idle(3);
    sample(16'hFFFF);
    check_all("sat_lo_high", 0, 0, 1, 16'd5);
    for (int i = 0; i < 6; i++) begin sample(16'h0000); seen |= rise | fall; end
    check("sat_lo_never_below", seen, 1'b0);
    check("sat_lo_level", level, 1'b1);

    // enable low holds level/count, re-acquire without pulse
    thr = 16'h8000; idle(3);
    sample(16'h9000);
    check_all("en_acq_high", 0, 0, 1, 16'd5);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin sample(16'h7000); seen |= rise | fall; end
    check("en_off_no_pulse", seen, 1'b0);
    check_all("en_off_hold", 0, 0, 1, 16'd5);
    enable = 1'b1;
    sample(16'h7000);
    check_all("en_reacq_low", 0, 0, 0, 16'd5);
    for (int i = 0; i < 4; i++) sample(16'h9000);
    check_all("en_rise", 1, 0, 1, 16'd6);
    enable = 1'b0;
    idle(1);
    check_all("pulse_ends_en_off", 0, 0, 1, 16'd6);
    enable = 1'b1;

    // reset in the middle of QUAL_FALL, on the completing sample
    sample(16'h9000);
    for (int i = 0; i < 3; i++) sample(16'h7000);
    check("qual_fall_pending", fall, 1'b0);
    reset_n = 1'b0;
    sample(16'h7000);
    check_all("reset_mid_qual", 0, 0, 0, 16'd0);
    reset_n = 1'b1;
    idle(3);

    // edge_count saturation on the HOLD_SAMPLES=1 instance
    adc_valid2 = 1'b1;
    adc_data2 = 16'h0000; tick();
    adc_data2 = 16'hFFFF; tick();
    check("h1_rise", rise2, 1'b1);
    check("h1_count", count2, 16'd1);
    for (int i = 2; i < 65535; i++) begin
      adc_data2 = i[0] ? 16'hFFFF : 16'h0000;
      tick();
    end
    check("h1_count_fffe", count2, 16'hFFFE);
    adc_data2 = 16'hFFFF; tick();
    check("h1_count_ffff", count2, 16'hFFFF);
    check("h1_rise_at_sat", rise2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      adc_data2 = i[0] ? 16'hFFFF : 16'h0000;
      tick();
    end
    check("h1_count_held", count2, 16'hFFFF);
    check("h1_level", level2, 1'b1);
    adc_valid2 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
